// File: rtl/msrv32_alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and opcode
// behind a 2-entry valid/ready skid buffer. Optional perf counters: MSRV32_ISSUE_PERF_EN.
module msrv32_alu_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic            flush_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [XLEN-1:0] op1_out,
    output logic [XLEN-1:0] op2_out,
    output logic [3:0]      alu_opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic            rd_wr_en_out,
    output logic            illegal_out,
    output logic [XLEN-1:0] pc_out
`ifdef MSRV32_ISSUE_PERF_EN
    ,
    output logic [31:0]     issue_count_out,
    output logic [31:0]     stall_count_out
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [3:0] ALU_ADD    = 4'b0000;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            rd_wr_en;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
    typedef enum logic [1:0] {HEAD_HOLD, HEAD_DEC, HEAD_TAIL, HEAD_CLR} head_act_t;

    state_t    r_state, w_state_next;
    head_act_t w_head_act;
    logic      w_load_tail;
    logic      r_in_ready, r_out_valid;
    logic      w_accept, w_drain;
    entry_t    r_head, r_tail, w_dec;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_is_shift;
    logic            w_legal;
    logic [XLEN-1:0] w_op1, w_op2;
    logic [3:0]      w_alu_op;
    logic            w_unused_rs1_field;

    assign w_opcode           = instr_in[6:0];
    assign w_funct3           = instr_in[14:12];
    assign w_funct7           = instr_in[31:25];
    assign w_is_shift         = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_unused_rs1_field = ^instr_in[19:15];

    // Instruction decode into operand pair and ALU opcode
    always_comb begin
        w_legal  = 1'b0;
        w_op1    = '0;
        w_op2    = '0;
        w_alu_op = ALU_ADD;
        case (w_opcode)
            OPC_OP: begin
                w_legal  = (w_funct7 == F7_ZERO) ||
                           ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
                w_op1    = rs1_data_in;
                w_op2    = w_is_shift ? {{(XLEN-5){1'b0}}, rs2_data_in[4:0]} : rs2_data_in;
                w_alu_op = {instr_in[30], w_funct3};
            end
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == F7_ZERO);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                end else begin
                    w_legal = 1'b1;
                end
                w_op1    = rs1_data_in;
                w_op2    = w_is_shift ? {{(XLEN-5){1'b0}}, instr_in[24:20]}
                                      : {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
                w_alu_op = {(w_funct3 == 3'b101) ? instr_in[30] : 1'b0, w_funct3};
            end
            OPC_LUI: begin
                w_legal = 1'b1;
                w_op2   = {instr_in[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_legal = 1'b1;
                w_op1   = pc_in;
                w_op2   = {instr_in[31:12], 12'b0};
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal encodings still issue, but with a zeroed datapath and no writeback
    always_comb begin
        w_dec          = '0;
        w_dec.rd       = instr_in[11:7];
        w_dec.pc       = pc_in;
        w_dec.illegal  = !w_legal;
        w_dec.rd_wr_en = w_legal && (instr_in[11:7] != 5'd0);
        if (w_legal) begin
            w_dec.op1    = w_op1;
            w_dec.op2    = w_op2;
            w_dec.alu_op = w_alu_op;
        end
    end

    assign w_accept = in_valid_in && r_in_ready;
    assign w_drain  = r_out_valid && out_ready_in;

    // Occupancy next-state and buffer steering
    always_comb begin
        w_state_next = r_state;
        w_head_act   = HEAD_HOLD;
        w_load_tail  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_ONE;
                    w_head_act   = HEAD_DEC;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_head_act   = HEAD_DEC;
                end else if (w_accept) begin
                    w_state_next = ST_TWO;
                    w_load_tail  = 1'b1;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                    w_head_act   = HEAD_CLR;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_state_next = ST_ONE;
                    w_head_act   = HEAD_TAIL;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        if (flush_in) begin
            w_state_next = ST_EMPTY;
            w_head_act   = HEAD_CLR;
            w_load_tail  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_TWO);
            r_out_valid <= (w_state_next != ST_EMPTY);
        end
    end

    // Head always holds the oldest entry; it is zeroed whenever the stage empties
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (w_head_act)
                HEAD_DEC:  r_head <= w_dec;
                HEAD_TAIL: r_head <= r_tail;
                HEAD_CLR:  r_head <= '0;
                default:   r_head <= r_head;
            endcase
            if (w_load_tail) begin
                r_tail <= w_dec;
            end
        end
    end

    assign in_ready_out   = r_in_ready;
    assign out_valid_out  = r_out_valid;
    assign op1_out        = r_head.op1;
    assign op2_out        = r_head.op2;
    assign alu_opcode_out = r_head.alu_op;
    assign rd_addr_out    = r_head.rd;
    assign rd_wr_en_out   = r_head.rd_wr_en;
    assign illegal_out    = r_head.illegal;
    assign pc_out         = r_head.pc;

`ifdef MSRV32_ISSUE_PERF_EN
    logic [31:0] r_issue_count, r_stall_count;

    // Free-running event counters, untouched by flush
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_drain) begin
                r_issue_count <= r_issue_count + 32'd1;
            end
            if (r_out_valid && !out_ready_in) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign issue_count_out = r_issue_count;
    assign stall_count_out = r_stall_count;
`endif

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Self-checking bench for msrv32_alu_issue: hand-computed stimulus table, queue scoreboard,
// backpressure, flush and reset scenarios. Counter ports connected when MSRV32_ISSUE_PERF_EN is set.
module tb_msrv32_alu_issue;

    localparam int unsigned NT = 16;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk_in, rst_n_in, in_valid_in, in_ready_out, flush_in;
    logic        out_valid_out, out_ready_in;
    logic [31:0] instr_in, pc_in, rs1_data_in, rs2_data_in;
    logic [31:0] op1_out, op2_out, pc_out;
    logic [3:0]  alu_opcode_out;
    logic [4:0]  rd_addr_out;
    logic        rd_wr_en_out, illegal_out;
`ifdef MSRV32_ISSUE_PERF_EN
    logic [31:0] issue_count_out, stall_count_out;
`endif

    msrv32_alu_issue #(.XLEN(32)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .in_valid_in    (in_valid_in),
        .in_ready_out   (in_ready_out),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .rs1_data_in    (rs1_data_in),
        .rs2_data_in    (rs2_data_in),
        .flush_in       (flush_in),
        .out_valid_out  (out_valid_out),
        .out_ready_in   (out_ready_in),
        .op1_out        (op1_out),
        .op2_out        (op2_out),
        .alu_opcode_out (alu_opcode_out),
        .rd_addr_out    (rd_addr_out),
        .rd_wr_en_out   (rd_wr_en_out),
        .illegal_out    (illegal_out),
        .pc_out         (pc_out)
`ifdef MSRV32_ISSUE_PERF_EN
        ,
        .issue_count_out(issue_count_out),
        .stall_count_out(stall_count_out)
`endif
    );

    logic [31:0] t_instr [NT];
    logic [31:0] t_pc    [NT];
    logic [31:0] t_rs1   [NT];
    logic [31:0] t_rs2   [NT];
    exp_t        t_exp   [NT];
    exp_t        q[$];
    int          checks;
    int          fails;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic exp_t obs();
        return {op1_out, op2_out, alu_opcode_out, rd_addr_out, rd_wr_en_out, illegal_out, pc_out};
    endfunction

    task automatic add(input int i, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [3:0] opc, input logic [4:0] rd,
                       input logic wr, input logic ill);
        t_instr[i] = ins; t_pc[i] = pc; t_rs1[i] = r1; t_rs2[i] = r2;
        t_exp[i]   = {e1, e2, opc, rd, wr, ill, pc};
    endtask

    task automatic init_tbl();
        add(0,  32'h002081B3, 32'h1000, 32'd5,        32'd7,        32'd5,        32'd7,        4'b0000, 5'd3,  1, 0); // ADD
        add(1,  32'h402081B3, 32'h1004, 32'd10,       32'd3,        32'd10,       32'd3,        4'b1000, 5'd3,  1, 0); // SUB
        add(2,  32'h4030D213, 32'h1008, 32'h80000000, 32'h0,        32'h80000000, 32'd3,        4'b1101, 5'd4,  1, 0); // SRAI
        add(3,  32'h00209333, 32'h100C, 32'hF,        32'h123,      32'hF,        32'h3,        4'b0001, 5'd6,  1, 0); // SLL
        add(4,  32'h0000007F, 32'h1010, 32'h55,       32'h66,       32'h0,        32'h0,        4'b0000, 5'd0,  0, 1); // bad opcode
        add(5,  32'h022083B3, 32'h1014, 32'h11,       32'h22,       32'h0,        32'h0,        4'b0000, 5'd7,  0, 1); // funct7=1
        add(6,  32'h123452B7, 32'h1018, 32'hAA,       32'hBB,       32'h0,        32'h12345000, 4'b0000, 5'd5,  1, 0); // LUI
        add(7,  32'hABCDE417, 32'h0100, 32'hAA,       32'hBB,       32'h100,      32'hABCDE000, 4'b0000, 5'd8,  1, 0); // AUIPC
        add(8,  32'hFFF08493, 32'h1020, 32'h20,       32'h0,        32'h20,       32'hFFFFFFFF, 4'b0000, 5'd9,  1, 0); // ADDI -1
        add(9,  32'h7FF0C513, 32'h1024, 32'h3,        32'h0,        32'h3,        32'h7FF,      4'b0100, 5'd10, 1, 0); // XORI
        add(10, 32'h0020B033, 32'h1028, 32'd1,        32'd2,        32'd1,        32'd2,        4'b0011, 5'd0,  0, 0); // SLTU rd=x0
        add(11, 32'h40209593, 32'h102C, 32'h9,        32'h0,        32'h0,        32'h0,        4'b0000, 5'd11, 0, 1); // SLLI alt
        add(12, 32'h4020D633, 32'h1030, 32'hF0000000, 32'hFFFFFFE5, 32'hF0000000, 32'h5,        4'b1101, 5'd12, 1, 0); // SRA
        add(13, 32'h4020E6B3, 32'h1034, 32'h7,        32'h8,        32'h0,        32'h0,        4'b0000, 5'd13, 0, 1); // OR alt
        add(14, 32'h01F0D713, 32'h1038, 32'h80000000, 32'h0,        32'h80000000, 32'd31,       4'b0101, 5'd14, 1, 0); // SRLI 31
        add(15, 32'h8000A793, 32'h103C, 32'h1,        32'h0,        32'h1,        32'hFFFFF800, 4'b0010, 5'd15, 1, 0); // SLTI min
    endtask

    task automatic drive(input bit v, input int i);
        in_valid_in = v;
        instr_in    = v ? t_instr[i] : 32'h0;
        pc_in       = v ? t_pc[i]    : 32'h0;
        rs1_data_in = v ? t_rs1[i]   : 32'h0;
        rs2_data_in = v ? t_rs2[i]   : 32'h0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; flush_in = 1'b0; out_ready_in = 1'b0;
        drive(0, 0);
        repeat (2) @(negedge clk_in);
        checks++;
        if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1 || obs() !== '0) begin
            fails++;
            $display("FAIL reset_hold: valid=%b ready=%b data=%h required valid=0 ready=1 data=0",
                     out_valid_out, in_ready_out, obs());
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1 || obs() !== '0) begin
            fails++;
            $display("FAIL reset_release: valid=%b ready=%b data=%h required valid=0 ready=1 data=0",
                     out_valid_out, in_ready_out, obs());
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_decode();
        exp_t e;
        for (int c = 0; c < int'(NT) + 4; c++) begin
            drive(c < int'(NT), c);
            out_ready_in = 1'b1;
            @(negedge clk_in);
            if (c == 1) begin
                checks++;
                if (out_valid_out !== 1'b1) begin
                    fails++;
                    $display("FAIL latency: out_valid=%b required 1", out_valid_out);
                end
            end
            if (out_valid_out && out_ready_in) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL decode_spurious: got %h required no entry", obs());
                end else begin
                    e = q.pop_front();
                    if (obs() !== e) begin
                        fails++;
                        $display("FAIL decode: got %h required %h", obs(), e);
                    end
                end
            end
            if (in_valid_in && in_ready_out && !flush_in) q.push_back(t_exp[c]);
            @(posedge clk_in); #1;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL decode_drain: %0d entries left, required 0", q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   nxt = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready_in = (c >= 5);
            drive(nxt < 3, 6 + nxt);
            @(negedge clk_in);
            if (c >= 2 && c < 5) begin
                checks++;
                if (in_ready_out !== 1'b0 || out_valid_out !== 1'b1 || q.size() == 0 || obs() !== q[0]) begin
                    fails++;
                    $display("FAIL bp_hold: ready=%b valid=%b data=%h required ready=0 valid=1 data=%h",
                             in_ready_out, out_valid_out, obs(), t_exp[6]);
                end
            end
            if (out_valid_out && out_ready_in) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_spurious: got %h required no entry", obs());
                end else begin
                    e = q.pop_front();
                    if (obs() !== e) begin
                        fails++;
                        $display("FAIL bp_order: got %h required %h", obs(), e);
                    end
                end
            end
            if (in_valid_in && in_ready_out && !flush_in) begin
                q.push_back(t_exp[6 + nxt]);
                nxt++;
            end
            @(posedge clk_in); #1;
        end
        checks++;
        if (q.size() != 0 || nxt != 3) begin
            fails++;
            $display("FAIL bp_complete: left=%0d accepted=%0d required left=0 accepted=3", q.size(), nxt);
        end
    endtask

    task automatic test_flush();
        out_ready_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1, c);
            @(posedge clk_in); #1;
        end
        drive(1, 2);
        flush_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (in_ready_out !== 1'b0 || out_valid_out !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre_two: ready=%b valid=%b required ready=0 valid=1", in_ready_out, out_valid_out);
        end
        @(posedge clk_in); #1;
        flush_in = 1'b0; drive(0, 0); out_ready_in = 1'b1;
        q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            checks++;
            if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1) begin
                fails++;
                $display("FAIL flush_two: cycle %0d valid=%b ready=%b required valid=0 ready=1",
                         c, out_valid_out, in_ready_out);
            end
        end
        @(posedge clk_in); #1;
        out_ready_in = 1'b0;
        drive(1, 3);
        @(posedge clk_in); #1;
        drive(1, 4);
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0; drive(0, 0);
        @(negedge clk_in);
        checks++;
        if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL flush_one_accept: valid=%b ready=%b required valid=0 ready=1", out_valid_out, in_ready_out);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset_midstream();
        out_ready_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1, 8 + c);
            @(posedge clk_in); #1;
        end
        drive(0, 0);
        checks++;
        if (in_ready_out !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset_two: ready=%b required 0", in_ready_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1 || obs() !== '0) begin
            fails++;
            $display("FAIL async_reset: valid=%b ready=%b data=%h required valid=0 ready=1 data=0",
                     out_valid_out, in_ready_out, obs());
        end
`ifdef MSRV32_ISSUE_PERF_EN
        checks++;
        if (issue_count_out !== 32'd0 || stall_count_out !== 32'd0) begin
            fails++;
            $display("FAIL perf_reset: issue=%0d stall=%0d required 0 0", issue_count_out, stall_count_out);
        end
`endif
        @(negedge clk_in);
        rst_n_in = 1'b1;
        q.delete();
        @(negedge clk_in);
        checks++;
        if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL post_reset: valid=%b ready=%b required valid=0 ready=1", out_valid_out, in_ready_out);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        init_tbl();
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msrv32_alu_issue.md
Name: msrv32_alu_issue

Overview:
- Decode/issue stage that drives the RV32I integer ALU: converts a decoded instruction plus register-file read data into the ALU operand pair and 4-bit ALU opcode.
- Registered, valid/ready pipeline stage with a 2-entry skid buffer.
- Sits between register-file read and the ALU/execute stage. Covers OP, OP-IMM, LUI and AUIPC.

Parameters:
- XLEN, 32, datapath width; only 32 supported.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- in_valid_in  input  1  upstream entry valid.
- in_ready_out  output  1  stage can accept an entry.
- instr_in  input  32  raw instruction word.
- pc_in  input  32  instruction PC.
- rs1_data_in  input  32  register-file rs1 data.
- rs2_data_in  input  32  register-file rs2 data.
- flush_in  input  1  synchronous pipeline flush.
- out_valid_out  output  1  issued entry valid.
- out_ready_in  input  1  ALU/execute stage accepts the entry.
- op1_out  output  32  ALU operand 1.
- op2_out  output  32  ALU operand 2.
- alu_opcode_out  output  4  ALU opcode.
- rd_addr_out  output  5  destination register.
- rd_wr_en_out  output  1  writeback enable.
- illegal_out  output  1  instruction not handled by this stage.
- pc_out  output  32  PC of the issued entry.

Behaviour:
- Reset:
  - Asynchronous, active-low; clears all entries; state EMPTY.
  - During and after reset: all data outputs 0, out_valid_out=0, in_ready_out=1.
- Occupancy FSM states: EMPTY, ONE, TWO.
  - Accept = in_valid_in && in_ready_out.
  - Drain = out_valid_out && out_ready_in.
  - EMPTY: Accept -> ONE.
  - ONE: Accept only -> TWO; Drain only -> EMPTY; Accept and Drain in the same cycle -> ONE.
  - TWO: Drain -> ONE. No accept is possible in TWO.
- Handshake signals:
  - in_ready_out = (state != TWO); it is registered state, not a combinational path from out_ready_in.
  - out_valid_out = (state != EMPTY).
  - Outputs always present the oldest entry; the second entry is promoted on Drain.
  - Output data must be stable while out_valid_out && !out_ready_in.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 if the stage was empty.
- Flush:
  - flush_in=1 -> EMPTY on the next edge; both entries are discarded.
  - An Accept in the same cycle is also discarded.
  - flush_in has priority over all other events.
- ALU opcode encoding: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101.
- OP (opcode 0110011):
  - op1 = rs1_data_in; op2 = rs2_data_in; alu_opcode = {instr[30], funct3}.
  - Shifts (funct3 001/101): op2 = {27'b0, rs2_data_in[4:0]}.
  - Legal funct7 values: 0000000, or 0100000 with funct3 000/101 only.
- OP-IMM (opcode 0010011):
  - op1 = rs1_data_in; op2 = sign-extended instr[31:20].
  - alu_opcode = {(funct3==101) ? instr[30] : 0, funct3}.
  - Shifts: op2 = {27'b0, instr[24:20]}.
  - Legal shift encodings: SLLI requires instr[31:25]=0; SRLI/SRAI require instr[31:25] = 0000000 or 0100000.
- LUI (opcode 0110111): op1 = 0; op2 = {instr[31:12], 12'b0}; opcode ADD.
- AUIPC (opcode 0010111): op1 = pc_in; op2 = U-immediate; opcode ADD.
- Illegal or unsupported encodings:
  - The entry is still issued with illegal_out=1, op1=op2=0, opcode 0000, rd_wr_en_out=0.
- Writeback enable: rd_wr_en_out = legal && (instr[11:7] != 0).
- Pass-through: rd_addr_out = instr[11:7]; pc_out = pc_in.
- Decode is performed before the entry is stored; entries hold decoded fields.

Optional Feature:
- Macro: MSRV32_ISSUE_PERF_EN.
- Defined: adds output ports issue_count_out[31:0] and stall_count_out[31:0].
  - issue_count_out increments on each Drain.
  - stall_count_out increments each cycle out_valid_out && !out_ready_in.
  - Both clear on reset, wrap modulo 2^32, and are not affected by flush_in.
- Not defined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready_in=1 -> next cycle op1=5, op2=7, opcode 0000, rd=3, rd_wr_en=1; then SUB (instr[30]=1) -> opcode 1000.
- SRAI x4,x1,3 (instr 0x4030D213) with rs1=0x80000000 -> op2=3, opcode 1101. SLL with rs2=0x00000123 -> op2=0x03.
- Backpressure: out_ready_in=0 while feeding 3 valid entries -> state reaches TWO, in_ready_out=0, third entry held upstream, outputs stable. Then out_ready_in=1 -> entries drain in order with no loss.
- flush_in=1 in state TWO with a simultaneous in_valid_in -> next cycle out_valid_out=0, in_ready_out=1, no entries issued.
- Illegal: instr 0x0000007F, then OP with funct7=0000001 -> illegal_out=1, rd_wr_en_out=0, op1=op2=0. LUI x5,0x12345 -> op2=0x12345000; AUIPC with pc=0x100 -> op1=0x100.
- Assert rst_n_in low mid-stream in state TWO -> immediately out_valid_out=0, outputs 0, in_ready_out=1. With MSRV32_ISSUE_PERF_EN defined, counters also read 0.
